// File: rtl/packet_planner_space_release_if.sv
// Descriptor intake, completion reports and release-pointer status between the
// packet planner, the buffer consumer and the space-release block.
interface packet_planner_space_release_if #(
    parameter int ITEMS      = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 14,
    parameter int FIFO_ITEMS = 64
);
    localparam int CNT_W = $clog2(ITEMS + 1);
    localparam int OCC_W = $clog2(FIFO_ITEMS) + 1;

    logic [ITEMS*(ADDR_WIDTH+LEN_WIDTH)-1:0] rx_data;
    logic [ITEMS-1:0]                        rx_vld;
    logic                                    rx_src_rdy;
    logic                                    rx_dst_rdy;
    logic [CNT_W-1:0]                        done_cnt;
    logic                                    done_vld;
    logic [ADDR_WIDTH-1:0]                   rd_ptr;
    logic [OCC_W-1:0]                        occupancy;
    logic                                    err_underflow;

    modport master (
        output rx_data, rx_vld, rx_src_rdy, done_cnt, done_vld,
        input  rx_dst_rdy, rd_ptr, occupancy, err_underflow
    );

    modport slave (
        input  rx_data, rx_vld, rx_src_rdy, done_cnt, done_vld,
        output rx_dst_rdy, rd_ptr, occupancy, err_underflow
    );
endinterface

// File: rtl/packet_planner_space_release.sv
// Holds planned packet descriptors in order and advances the buffer release
// pointer as the consumer reports completed packets.
module packet_planner_space_release #(
    parameter int ITEMS      = 2,
    parameter int SPACE_SIZE = 4096,
    parameter int ADDR_WIDTH = $clog2(SPACE_SIZE),
    parameter int LEN_WIDTH  = 14,
    parameter int ALIGN      = 8,
    parameter int FIFO_ITEMS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    packet_planner_space_release_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_ITEMS) + 1;
    localparam int IDX_W  = $clog2(FIFO_ITEMS);
    localparam int DESC_W = ADDR_WIDTH + LEN_WIDTH;
    localparam int SUM_W  = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

    logic [DESC_W-1:0]     r_mem [FIFO_ITEMS];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_rel_addr;
    logic                  r_dst_rdy;
    logic                  r_err;

    logic                  w_push;
    logic [PTR_W-1:0]      w_occ;
    logic [PTR_W-1:0]      w_occ_next;
    logic [PTR_W-1:0]      w_push_cnt;
    logic [PTR_W-1:0]      w_pop_cnt;
    logic [PTR_W-1:0]      w_done_ext;
    logic [PTR_W-1:0]      w_slot [ITEMS];
    logic [DESC_W-1:0]     w_last;

    // End of a descriptor's allocation: address plus length rounded up to ALIGN,
    // wrapped into the buffer.
    function automatic logic [ADDR_WIDTH-1:0] release_ptr(input logic [DESC_W-1:0] d);
        logic [SUM_W-1:0] len_al;
        logic [SUM_W-1:0] sum;
        len_al = (SUM_W'(d[DESC_W-1:ADDR_WIDTH]) + SUM_W'(ALIGN - 1)) & ~SUM_W'(ALIGN - 1);
        sum    = SUM_W'(d[ADDR_WIDTH-1:0]) + len_al;
        return sum[ADDR_WIDTH-1:0];
    endfunction

    always_comb begin
        w_occ      = r_wr_ptr - r_rd_ptr;
        w_push     = bus.rx_src_rdy & r_dst_rdy;
        w_push_cnt = '0;
        // Valid items are packed into consecutive slots in item order.
        for (int i = 0; i < ITEMS; i++) begin
            w_slot[i] = r_wr_ptr + w_push_cnt;
            if (w_push && bus.rx_vld[i]) w_push_cnt = w_push_cnt + PTR_W'(1);
        end
        w_done_ext = PTR_W'(bus.done_cnt);
        w_pop_cnt  = '0;
        if (bus.done_vld) w_pop_cnt = (w_done_ext > w_occ) ? w_occ : w_done_ext;
        w_last     = r_mem[IDX_W'(r_rd_ptr + w_pop_cnt - PTR_W'(1))];
        w_occ_next = w_occ + w_push_cnt - w_pop_cnt;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ITEMS; i++) begin
            if (w_push && bus.rx_vld[i])
                r_mem[IDX_W'(w_slot[i])] <= bus.rx_data[i*DESC_W +: DESC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rel_addr <= '0;
            r_dst_rdy  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + w_push_cnt;
            r_rd_ptr  <= r_rd_ptr + w_pop_cnt;
            // Ready depends only on registered state, never on this cycle's inputs.
            r_dst_rdy <= (PTR_W'(FIFO_ITEMS) - w_occ_next) >= PTR_W'(ITEMS);
            if (w_pop_cnt != '0) r_rel_addr <= release_ptr(w_last);
            if (bus.done_vld && (w_done_ext > w_occ)) r_err <= 1'b1;
        end
    end

    assign bus.rx_dst_rdy    = r_dst_rdy;
    assign bus.rd_ptr        = r_rel_addr;
    assign bus.occupancy     = w_occ;
    assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_packet_planner_space_release.sv
// Directed bench for packet_planner_space_release with a queue model for the
// fill/drain and streaming phases.
module tb_packet_planner_space_release;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   qa[$];
    int   ql[$];
    int   rd_exp;
    int   peak;
    int   k;

    always #5 clk = ~clk;

    packet_planner_space_release_if #(.ITEMS(2), .ADDR_WIDTH(12), .LEN_WIDTH(14), .FIFO_ITEMS(64)) bus ();

    packet_planner_space_release #(
        .ITEMS(2), .SPACE_SIZE(4096), .ADDR_WIDTH(12), .LEN_WIDTH(14), .ALIGN(8), .FIFO_ITEMS(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int rel(input int a, input int l);
        return (a + ((l + 7) / 8) * 8) % 4096;
    endfunction

    task automatic cycle(input logic [1:0] vld, input int a0, input int l0, input int a1, input int l1,
                         input logic src, input int dcnt, input logic dvld);
        bus.rx_vld     = vld;
        bus.rx_data    = {14'(l1), 12'(a1), 14'(l0), 12'(a0)};
        bus.rx_src_rdy = src;
        bus.done_cnt   = 2'(dcnt);
        bus.done_vld   = dvld;
        @(posedge clk);
        #1;
        bus.rx_vld     = '0;
        bus.rx_data    = '0;
        bus.rx_src_rdy = 1'b0;
        bus.done_cnt   = '0;
        bus.done_vld   = 1'b0;
    endtask

    // Full-width push of two descriptors plus optional completion, tracked by the model.
    task automatic cycle_m(input int a0, input int l0, input int a1, input int l1,
                           input logic src, input int dcnt);
        logic acc;
        int   n;
        acc = src && bus.rx_dst_rdy;
        n   = (dcnt > qa.size()) ? qa.size() : dcnt;
        cycle(2'b11, a0, l0, a1, l1, src, dcnt, dcnt != 0);
        for (int j = 0; j < n; j++) begin
            rd_exp = rel(qa[0], ql[0]);
            void'(qa.pop_front());
            void'(ql.pop_front());
        end
        if (acc) begin
            qa.push_back(a0); ql.push_back(l0);
            qa.push_back(a1); ql.push_back(l1);
        end
        if (qa.size() > peak) peak = qa.size();
        check("model_occ", 32'(bus.occupancy), 32'(qa.size()));
        check("model_rdptr", 32'(bus.rd_ptr), 32'(rd_exp));
    endtask

    initial begin
        bus.rx_vld = '0; bus.rx_data = '0; bus.rx_src_rdy = 1'b0;
        bus.done_cnt = '0; bus.done_vld = 1'b0;

        // Reset held for five cycles
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_rdy", 32'(bus.rx_dst_rdy), 0);
        end
        check("rst_rdptr", 32'(bus.rd_ptr), 0);
        check("rst_occ", 32'(bus.occupancy), 0);
        check("rst_err", 32'(bus.err_underflow), 0);
        rst = 1'b0;
        #1;
        check("rel_rdy_early", 32'(bus.rx_dst_rdy), 0);
        @(posedge clk); #1;
        check("rel_rdy", 32'(bus.rx_dst_rdy), 1);

        // Single packet
        cycle(2'b01, 0, 60, 0, 0, 1'b1, 0, 1'b0);
        check("single_occ1", 32'(bus.occupancy), 1);
        check("single_rd_hold", 32'(bus.rd_ptr), 0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1, 1'b1);
        check("single_rdptr", 32'(bus.rd_ptr), 64);
        check("single_occ0", 32'(bus.occupancy), 0);

        // Sparse and multi-item words
        cycle(2'b10, 0, 0, 64, 1, 1'b1, 0, 1'b0);
        check("sparse_occ", 32'(bus.occupancy), 1);
        cycle(2'b11, 72, 8, 80, 100, 1'b1, 0, 1'b0);
        check("multi_occ", 32'(bus.occupancy), 3);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 2, 1'b1);
        check("multi_rd80", 32'(bus.rd_ptr), 80);
        check("multi_occ1", 32'(bus.occupancy), 1);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1, 1'b1);
        check("multi_rd184", 32'(bus.rd_ptr), 184);

        // Word with no valid items is accepted and ignored; DONE_VLD low does nothing
        cycle(2'b00, 500, 5, 600, 6, 1'b1, 2, 1'b0);
        check("empty_word_occ", 32'(bus.occupancy), 0);
        check("dvld_low_rd", 32'(bus.rd_ptr), 184);

        // Wrap past the end of the buffer
        cycle(2'b01, 4088, 20, 0, 0, 1'b1, 0, 1'b0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1, 1'b1);
        check("wrap_rdptr", 32'(bus.rd_ptr), 16);

        // Zero length releases nothing beyond its address
        cycle(2'b01, 40, 0, 0, 0, 1'b1, 0, 1'b0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1, 1'b1);
        check("len0_rdptr", 32'(bus.rd_ptr), 40);

        // Fill with no completions, offering words even while not ready
        rd_exp = 40;
        peak   = 0;
        k      = 0;
        for (int c = 0; c < 40; c++) begin
            cycle_m((k * 40) % 4096, k * 3 + 1, ((k + 1) * 40) % 4096, k * 5 + 2, 1'b1, 0);
            check("full_rdy", 32'(bus.rx_dst_rdy), 32'((64 - qa.size()) >= 2));
            k += 2;
        end
        check("full_peak", 32'(peak), 64);
        check("full_occ64", 32'(bus.occupancy), 64);

        // Drain two per cycle, checking each released pointer
        for (int c = 0; c < 32; c++) cycle_m(0, 0, 0, 0, 1'b0, 2);
        check("drain_empty", 32'(bus.occupancy), 0);

        // Streaming: two in and two out every cycle
        cycle_m(8, 9, 24, 31, 1'b1, 0);
        for (int c = 0; c < 6; c++) cycle_m(100 + c * 64, c + 3, 132 + c * 64, 2 * c, 1'b1, 2);
        cycle_m(0, 0, 0, 0, 1'b0, 2);
        check("stream_rdy", 32'(bus.rx_dst_rdy), 1);

        // Underflow: one outstanding, two completed
        cycle(2'b01, 100, 4, 0, 0, 1'b1, 0, 1'b0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 2, 1'b1);
        check("uf_occ", 32'(bus.occupancy), 0);
        check("uf_rdptr", 32'(bus.rd_ptr), 108);
        check("uf_err", 32'(bus.err_underflow), 1);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0);
        check("uf_sticky", 32'(bus.err_underflow), 1);

        // Reset mid-operation drops held descriptors and clears the flag
        cycle(2'b01, 300, 8, 0, 0, 1'b1, 0, 1'b0);
        check("pre_rst_occ", 32'(bus.occupancy), 1);
        rst = 1'b1;
        #1;
        check("async_rst_occ", 32'(bus.occupancy), 0);
        check("async_rst_err", 32'(bus.err_underflow), 0);
        check("async_rst_rd", 32'(bus.rd_ptr), 0);
        check("async_rst_rdy", 32'(bus.rx_dst_rdy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rerelease_rdy", 32'(bus.rx_dst_rdy), 1);

        // Same-cycle push and completion at empty: push not poppable yet
        cycle(2'b01, 200, 16, 0, 0, 1'b1, 1, 1'b1);
        check("same_err", 32'(bus.err_underflow), 1);
        check("same_occ", 32'(bus.occupancy), 1);
        check("same_rd", 32'(bus.rd_ptr), 0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1, 1'b1);
        check("same_pop_rd", 32'(bus.rd_ptr), 216);
        check("same_pop_occ", 32'(bus.occupancy), 0);
        check("same_err_sticky", 32'(bus.err_underflow), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
